// File: rtl/genius_pixel_mem_arbiter_pkg.sv
// Shared types for the Genius pixel memory arbiter:
// memory geometry, fill command bundle and FSM states.
package genius_pkg;

  localparam int ADDR_W = 11;
  localparam int DEPTH  = 2048;
  localparam int DATA_W = 24;
  localparam int LEN_W  = ADDR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] color;
  } fill_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FILL
  } state_t;

  function automatic logic [ADDR_W-1:0] wrap_inc(
    input logic [ADDR_W-1:0] a
  );
    if (a == ADDR_W'(DEPTH - 1)) return '0;
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/genius_pixel_mem_arbiter_if.sv
// Fill-command handshake plus pixel memory bus
// between the game FSM, the arbiter and the memory.
interface genius_pixel_mem_arbiter_if;
  import genius_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_color;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              wren;
  logic              busy;
  logic              done;

  modport master (
    output cmd_valid, cmd_addr, cmd_len, cmd_color,
    input  cmd_ready, mem_addr, mem_data, wren,
    input  busy, done
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, cmd_color,
    output cmd_ready, mem_addr, mem_data, wren,
    output busy, done
  );

endinterface

// File: rtl/genius_cmd_fifo.sv
// Small synchronous FIFO holding queued fill commands.
// A push while full is only taken when a pop frees a slot.
module genius_cmd_fifo
  import genius_pkg::*;
#(
  parameter  int FIFO_DEPTH = 4,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  fill_cmd_t wdata,
  output fill_cmd_t rdata,
  output logic      full,
  output logic      empty,
  output logic [CW-1:0] count
);

  fill_cmd_t         mem [FIFO_DEPTH];
  logic [PW-1:0]     wp;
  logic [PW-1:0]     rp;
  logic [CW-1:0]     cnt_n;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rp];

  always_comb begin
    cnt_n = count;
    if (do_push && !do_pop)
      cnt_n = count + CW'(1);
    else if (!do_push && do_pop)
      cnt_n = count - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop)  rp <= rp + PW'(1);
      count <= cnt_n;
      full  <= (cnt_n == CW'(FIFO_DEPTH));
      empty <= (cnt_n == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/genius_pixel_mem_arbiter.sv
// Shares the pixel memory between VGA scan-out and
// queued colour fills that only write during blanking.
module genius_pixel_mem_arbiter
  import genius_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic CLOCK_25,
  input logic RESET_N,
  input logic DISP_EN,
  input logic VGA_VS,
  genius_pixel_mem_arbiter_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  fill_cmd_t         cur;
  fill_cmd_t         head;
  fill_cmd_t         cmd_in;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [LEN_W-1:0]  remaining;
  logic [DATA_W-1:0] color;
  logic              done_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_cnt;
  logic              push;
  logic              pop;
  logic              wr_cyc;

  assign push   = bus.cmd_valid && bus.cmd_ready;
  assign pop    = (state == IDLE) && !fifo_empty;
  assign cmd_in = '{addr:  bus.cmd_addr,
                    len:   bus.cmd_len,
                    color: bus.cmd_color};

  genius_cmd_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLOCK_25),
    .rst_n (RESET_N),
    .push  (push),
    .pop   (pop),
    .wdata (cmd_in),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Scan-out address; VS low re-arms the frame
  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N)
      rd_ptr <= '0;
    else if (!VGA_VS)
      rd_ptr <= '0;
    else if (DISP_EN)
      rd_ptr <= wrap_inc(rd_ptr);
  end

  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      cur       <= '0;
      wr_ptr    <= '0;
      remaining <= '0;
      color     <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            cur   <= head;
            state <= LOAD;
          end
        end
        LOAD: begin
          wr_ptr    <= cur.addr;
          remaining <= cur.len;
          color     <= cur.color;
          if (cur.len == '0) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end else begin
            state <= FILL;
          end
        end
        FILL: begin
          if (!DISP_EN) begin
            wr_ptr    <= wrap_inc(wr_ptr);
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              done_q <= 1'b1;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wr_cyc        = (state == FILL) && !DISP_EN;
  assign bus.wren      = wr_cyc;
  assign bus.mem_addr  = wr_cyc ? wr_ptr : rd_ptr;
  assign bus.mem_data  = color;
  assign bus.busy      = (state != IDLE) || (fifo_cnt != '0);
  assign bus.done      = done_q;
  assign bus.cmd_ready = !fifo_full;

endmodule

// File: tb/tb_genius_pixel_mem_arbiter.sv
// Scoreboard bench: offers queue expected writes and
// done pulses; a negedge monitor pops and compares.
module tb_genius_pixel_mem_arbiter;
  import genius_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic de    = 1'b0;
  logic vs    = 1'b1;

  always #5 clk = ~clk;

  genius_pixel_mem_arbiter_if bus();

  genius_pixel_mem_arbiter #(
    .FIFO_DEPTH(4)
  ) dut (
    .CLOCK_25 (clk),
    .RESET_N  (rst_n),
    .DISP_EN  (de),
    .VGA_VS   (vs),
    .bus      (bus)
  );

  typedef struct {
    logic [10:0] a;
    logic [23:0] d;
  } wr_t;

  wr_t  exp_wr[$];
  bit   exp_done[$];
  wr_t  mon_w;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_wr = 0;
  int   n_done = 0;
  bit   prev_wren = 1'b0;
  logic [10:0] rd_m;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Independent scan-out pointer model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)   rd_m <= '0;
    else if (!vs) rd_m <= '0;
    else if (de)  rd_m <= rd_m + 11'd1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wren) begin
        n_wr++;
        if (exp_wr.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: addr %0h data %0h",
                   bus.mem_addr, bus.mem_data);
        end else begin
          mon_w = exp_wr.pop_front();
          check("wr_addr", bus.mem_addr, mon_w.a);
          check("wr_data", bus.mem_data, mon_w.d);
          check("wr_in_blank", de, 0);
        end
      end else begin
        check("rd_addr", bus.mem_addr, rd_m);
      end
      if (bus.done) begin
        n_done++;
        if (exp_done.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got 1 expected 0");
        end else begin
          check("done_after_write", prev_wren,
                exp_done.pop_front());
        end
      end
      prev_wren = bus.wren;
    end else begin
      prev_wren = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [10:0] a,
                       input logic [11:0] l,
                       input logic [23:0] c,
                       output bit acc);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    bus.cmd_color = c;
    acc = bus.cmd_ready;
    if (acc) begin
      for (int i = 0; i < int'(l); i++)
        exp_wr.push_back('{a: 11'(int'(a) + i), d: c});
      exp_done.push_back(l != 0);
    end
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name,
                           input int budget);
    int k;
    k = 0;
    while ((bus.busy || exp_wr.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    check({name, "_timeout"}, k < budget, 1);
    check({name, "_wr_left"}, exp_wr.size(), 0);
    check({name, "_done_left"}, exp_done.size(), 0);
    check({name, "_busy"}, bus.busy, 0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit acc;
    bit accs[5];
    int k;
    int w0;
    int d0;

    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.cmd_color = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_wren", bus.wren, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_data", bus.mem_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    rst_n = 1'b1;
    tick();

    // basic fill with latency check
    w0 = n_wr;
    d0 = n_done;
    offer(11'h010, 12'd4, 24'hFF0000, acc);
    check("basic_acc", acc, 1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.wren && k < 10);
    check("basic_latency", k, 3);
    wait_idle("basic", 50);
    check("basic_nwr", n_wr - w0, 4);
    check("basic_ndone", n_done - d0, 1);

    // stall after three writes, resume in place
    w0 = n_wr;
    offer(11'h100, 12'd8, 24'h00FF00, acc);
    k = 0;
    while (n_wr - w0 < 3 && k < 20) begin
      tick();
      k++;
    end
    check("stall_reach3", n_wr - w0, 3);
    de = 1'b1;
    repeat (5) tick();
    check("stall_nwr_held", n_wr - w0, 3);
    de = 1'b0;
    wait_idle("stall", 50);
    check("stall_nwr", n_wr - w0, 8);

    // address wrap
    offer(11'h7FE, 12'd4, 24'h0000FF, acc);
    wait_idle("wrap", 50);

    // fifo full while active video holds a stalled fill
    d0 = n_done;
    de = 1'b1;
    offer(11'h300, 12'd2, 24'h111111, acc);
    repeat (4) tick();
    check("full_busy", bus.busy, 1);
    check("full_ready_pre", bus.cmd_ready, 1);
    offer(11'h310, 12'd2, 24'h222222, accs[0]);
    offer(11'h320, 12'd2, 24'h333333, accs[1]);
    offer(11'h330, 12'd2, 24'h444444, accs[2]);
    offer(11'h340, 12'd2, 24'h555555, accs[3]);
    offer(11'h350, 12'd2, 24'h666666, accs[4]);
    check("full_acc0", accs[0], 1);
    check("full_acc1", accs[1], 1);
    check("full_acc2", accs[2], 1);
    check("full_acc3", accs[3], 1);
    check("full_acc4", accs[4], 0);
    check("full_ready", bus.cmd_ready, 0);
    de = 1'b0;
    wait_idle("full", 100);
    check("full_ndone", n_done - d0, 5);

    // scan-out pointer sequence
    vs = 1'b0;
    tick();
    vs = 1'b1;
    de = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      check("rdseq_addr", bus.mem_addr, i);
      check("rdseq_wren", bus.wren, 0);
    end
    @(posedge clk);
    #1;
    de = 1'b0;
    @(negedge clk);
    check("rdseq_final", bus.mem_addr, 64);
    tick();

    // full-memory fill
    w0 = n_wr;
    offer(11'h123, 12'd2048, 24'hABCDEF, acc);
    wait_idle("len2048", 2200);
    check("len2048_nwr", n_wr - w0, 2048);

    // zero length
    w0 = n_wr;
    d0 = n_done;
    offer(11'h050, 12'd0, 24'h777777, acc);
    wait_idle("len0", 20);
    check("len0_nwr", n_wr - w0, 0);
    check("len0_ndone", n_done - d0, 1);

    // reset mid-fill
    w0 = n_wr;
    offer(11'h200, 12'd20, 24'h0F0F0F, acc);
    offer(11'h400, 12'd3, 24'h0A0A0A, acc);
    k = 0;
    while (n_wr - w0 < 2 && k < 20) begin
      tick();
      k++;
    end
    check("rstmid_writing", bus.wren, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_wren", bus.wren, 0);
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_ready", bus.cmd_ready, 1);
    check("rstmid_done", bus.done, 0);
    exp_wr.delete();
    exp_done.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("rstrel_busy", bus.busy, 0);
    check("rstrel_ready", bus.cmd_ready, 1);
    check("rstrel_wren", bus.wren, 0);
    offer(11'h020, 12'd1, 24'h123456, acc);
    wait_idle("postrst", 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
